// File: rtl/simd_pkg.sv
// Shared types for the command issuer: command/scoreboard payloads and FSM state codes.
package simd_pkg;

    localparam int unsigned CMD_ID_WIDTH  = 8;
    localparam int unsigned OPCODE_WIDTH  = 8;
    localparam int unsigned PROC_ID_WIDTH = 2;

    typedef struct packed {
        logic [CMD_ID_WIDTH-1:0] cmd_id;
        logic [CMD_ID_WIDTH-1:0] dep_id;
        logic [OPCODE_WIDTH-1:0] opcode;
    } cmd_t;

    typedef struct packed {
        logic [CMD_ID_WIDTH-1:0]  cmd_id;
        logic [PROC_ID_WIDTH-1:0] proc_id;
    } entry_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOOKUP   = 3'd1;
    localparam logic [2:0] ST_STALL    = 3'd2;
    localparam logic [2:0] ST_SELECT   = 3'd3;
    localparam logic [2:0] ST_DISPATCH = 3'd4;
    localparam logic [2:0] ST_RECORD   = 3'd5;
    localparam logic [2:0] ST_FLUSH    = 3'd6;

endpackage

// File: rtl/cmd_issuer_picker.sv
// Lowest-index priority encoder: reports whether any request bit is set and its index.
module proc_picker #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  free_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cmd_issuer.sv
// Command issuer: dependency lookup, processor dispatch and scoreboard record/flush.
// Optional statistics counters are built when ISSUER_STATS_EN is defined.
module cmd_issuer #(
    parameter int unsigned PROC_COUNT   = 4,
    parameter int unsigned ID_WIDTH     = $clog2(PROC_COUNT),
    parameter int unsigned CMD_ID_WIDTH = simd_pkg::CMD_ID_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  simd_pkg::cmd_t        i_cmd,
    output logic                  o_sb_read,
    output logic                  o_sb_write,
    output logic                  o_sb_flush,
    output simd_pkg::entry_t      o_sb_entry,
    input  logic                  i_sb_done,
    input  logic                  i_sb_exists,
    input  logic [ID_WIDTH-1:0]   i_sb_id,
    output logic [PROC_COUNT-1:0] o_proc_valid,
    output simd_pkg::cmd_t        o_proc_cmd,
    input  logic [PROC_COUNT-1:0] i_proc_busy,
    input  logic [PROC_COUNT-1:0] i_proc_done
`ifdef ISSUER_STATS_EN
    ,
    output logic [31:0]           o_issued_cnt,
    output logic [31:0]           o_stall_cnt
`endif
);

    import simd_pkg::*;

    localparam int unsigned PKG_CID_W = simd_pkg::CMD_ID_WIDTH;
    localparam int unsigned PKG_PID_W = simd_pkg::PROC_ID_WIDTH;

    logic [2:0]              state_q, state_d;
    cmd_t                    cmd_q, cmd_d;
    logic [PROC_COUNT-1:0]   occ_q, occ_d;
    logic [PROC_COUNT-1:0]   pend_q, pend_d;
    logic [PROC_COUNT-1:0]   clr_mask, disp_mask;
    logic [ID_WIDTH-1:0]     sel_q, sel_d;
    logic [ID_WIDTH-1:0]     fidx_q, fidx_d;
    logic                    ret_lookup_q, ret_lookup_d;
    logic [CMD_ID_WIDTH-1:0] tbl_q [PROC_COUNT];

    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    fl_q, fl_d;
    logic                    ready_q, ready_d;
    logic [PROC_COUNT-1:0]   pv_q, pv_d;
    entry_t                  entry_q, entry_d;

    logic                    pick_valid;
    logic [ID_WIDTH-1:0]     pick_idx;
    logic                    flush_valid;
    logic [ID_WIDTH-1:0]     flush_idx;

    // The scoreboard's reported owner id is not needed by this issuer.
    logic                    unused_sb_id;
    assign unused_sb_id = ^i_sb_id;

    proc_picker #(.N(PROC_COUNT), .IW(ID_WIDTH)) u_free_pick (
        .free_i  (~i_proc_busy & ~pend_q & ~occ_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    proc_picker #(.N(PROC_COUNT), .IW(ID_WIDTH)) u_flush_pick (
        .free_i  (pend_q),
        .valid_o (flush_valid),
        .idx_o   (flush_idx)
    );

    // Next-state, bookkeeping and registered-output look-ahead.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        sel_d        = sel_q;
        fidx_d       = fidx_q;
        ret_lookup_d = ret_lookup_q;
        clr_mask     = '0;
        disp_mask    = '0;

        case (state_q)
            ST_IDLE: begin
                if (flush_valid) begin
                    state_d      = ST_FLUSH;
                    fidx_d       = flush_idx;
                    ret_lookup_d = 1'b0;
                end else if (i_cmd_valid) begin
                    cmd_d   = i_cmd;
                    state_d = (i_cmd.dep_id != '0) ? ST_LOOKUP : ST_SELECT;
                end
            end
            ST_LOOKUP: begin
                if (i_sb_done) begin
                    state_d = i_sb_exists ? ST_STALL : ST_SELECT;
                end
            end
            ST_STALL: begin
                if (flush_valid) begin
                    state_d      = ST_FLUSH;
                    fidx_d       = flush_idx;
                    ret_lookup_d = 1'b1;
                end
            end
            ST_SELECT: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                disp_mask[sel_q] = 1'b1;
                state_d          = ST_RECORD;
            end
            ST_RECORD: begin
                if (i_sb_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (i_sb_done) begin
                    clr_mask[fidx_q] = 1'b1;
                    state_d          = ret_lookup_q ? ST_LOOKUP : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new completion always wins over the clear of a different processor.
        pend_d = (pend_q & ~clr_mask) | (i_proc_done & occ_q);
        occ_d  = (occ_q & ~clr_mask) | disp_mask;

        rd_d    = (state_d == ST_LOOKUP);
        wr_d    = (state_d == ST_RECORD);
        fl_d    = (state_d == ST_FLUSH);
        ready_d = (state_d == ST_IDLE) && (pend_d == '0);
        pv_d    = (state_d == ST_DISPATCH) ? (PROC_COUNT'(1) << sel_d) : '0;

        entry_d = '0;
        case (state_d)
            ST_LOOKUP: begin
                entry_d.cmd_id = PKG_CID_W'(cmd_d.dep_id);
            end
            ST_RECORD: begin
                entry_d.cmd_id  = PKG_CID_W'(cmd_q.cmd_id);
                entry_d.proc_id = PKG_PID_W'(sel_q);
            end
            ST_FLUSH: begin
                entry_d.cmd_id  = PKG_CID_W'(tbl_q[fidx_d]);
                entry_d.proc_id = PKG_PID_W'(fidx_d);
            end
            default: begin
                entry_d = '0;
            end
        endcase
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            occ_q        <= '0;
            pend_q       <= '0;
            sel_q        <= '0;
            fidx_q       <= '0;
            ret_lookup_q <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            fl_q         <= 1'b0;
            ready_q      <= 1'b0;
            pv_q         <= '0;
            entry_q      <= '0;
            for (int k = 0; k < int'(PROC_COUNT); k++) begin
                tbl_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            occ_q        <= occ_d;
            pend_q       <= pend_d;
            sel_q        <= sel_d;
            fidx_q       <= fidx_d;
            ret_lookup_q <= ret_lookup_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            fl_q         <= fl_d;
            ready_q      <= ready_d;
            pv_q         <= pv_d;
            entry_q      <= entry_d;
            if (state_q == ST_DISPATCH) begin
                tbl_q[sel_q] <= CMD_ID_WIDTH'(cmd_q.cmd_id);
            end
        end
    end

    assign o_cmd_ready  = ready_q;
    assign o_sb_read    = rd_q;
    assign o_sb_write   = wr_q;
    assign o_sb_flush   = fl_q;
    assign o_sb_entry   = entry_q;
    assign o_proc_valid = pv_q;
    assign o_proc_cmd   = cmd_q;

`ifdef ISSUER_STATS_EN
    logic [31:0] issued_q;
    logic [31:0] stall_q;

    // Dispatch count and cycles spent waiting on a dependency or a free processor.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            if (state_q == ST_DISPATCH) begin
                issued_q <= issued_q + 32'd1;
            end
            if ((state_q == ST_STALL) || ((state_q == ST_SELECT) && !pick_valid)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign o_issued_cnt = issued_q;
    assign o_stall_cnt  = stall_q;
`endif

endmodule
